axi_write_sink: RTL and testbench

AXI write-channel sink that sits directly downstream of the UMI-to-AXI write bridge in the riscv-grid example. It accepts write-address and write-data beats independently, commits each address/data pair into an internal 256-bit-wide memory, and returns one write response per pair. A side read port and two status counters let the surrounding testbench and software check what was written.

---
 rtl/axi_write_sink.sv | 134 +++++++++++++
 tb/tb_axi_write_sink.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_sink.sv
// AXI write-channel sink: holds one AW and one W beat, commits each pair into a
// 256-bit-wide memory, returns one B response per pair, and exposes a side read port.
module axi_write_sink #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          DEPTH     = 256,
  parameter int          AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          axi_awvalid,
  output logic          axi_awready,
  input  logic [63:0]   axi_awaddr,
  input  logic          axi_wvalid,
  output logic          axi_wready,
  input  logic [255:0]  axi_wdata,
  output logic          axi_bvalid,
  input  logic          axi_bready,
  output logic [1:0]    axi_bresp,
  input  logic [AW-1:0] rd_addr,
  output logic [255:0]  rd_data,
  output logic [31:0]   wr_count,
  output logic [15:0]   err_count
);

  // Handshakes: a beat transfers on the rising edge where valid & ready are both 1;
  // readies depend only on registered state, and B holds steady until bready.
  localparam logic [63:0] SPAN = 64'(DEPTH) << 5;

  logic           run_q, run_d;
  logic           aw_full_q, aw_full_d;
  logic [63:0]    aw_addr_q, aw_addr_d;
  logic           w_full_q, w_full_d;
  logic [255:0]   w_data_q, w_data_d;
  logic           bvalid_q, bvalid_d;
  logic [1:0]     bresp_q, bresp_d;
  logic [31:0]    wr_count_q, wr_count_d;
  logic [15:0]    err_count_q, err_count_d;
  logic [255:0]   rd_data_q, rd_data_d;
  logic [255:0]   mem [DEPTH];

  logic           aw_hs, w_hs, commit, in_range, mem_we;
  logic [63:0]    off;
  logic [AW-1:0]  wr_idx;

  assign axi_awready = run_q & ~aw_full_q;
  assign axi_wready  = run_q & ~w_full_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign rd_data     = rd_data_q;
  assign wr_count    = wr_count_q;
  assign err_count   = err_count_q;

  assign aw_hs    = axi_awvalid & axi_awready;
  assign w_hs     = axi_wvalid & axi_wready;
  // A pending response blocks the commit, so only one response is ever outstanding.
  assign commit   = aw_full_q & w_full_q & ~bvalid_q;
  assign off      = aw_addr_q - BASE_ADDR;
  assign in_range = (aw_addr_q >= BASE_ADDR) && (off < SPAN);
  assign wr_idx   = off[AW+4:5];
  assign mem_we   = commit & in_range;

  always_comb begin
    run_d       = 1'b1;
    aw_full_d   = aw_full_q;
    aw_addr_d   = aw_addr_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    wr_count_d  = wr_count_q;
    err_count_d = err_count_q;
    rd_data_d   = mem[rd_addr];

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = axi_awaddr;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = axi_wdata;
    end
    if (bvalid_q && axi_bready) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (in_range) begin
        bresp_d    = 2'b00;
        wr_count_d = wr_count_q + 32'd1;
      end else begin
        bresp_d = 2'b10;
        if (err_count_q != 16'hFFFF) begin
          err_count_d = err_count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      aw_full_q   <= 1'b0;
      aw_addr_q   <= '0;
      w_full_q    <= 1'b0;
      w_data_q    <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      wr_count_q  <= '0;
      err_count_q <= '0;
      rd_data_q   <= '0;
    end else begin
      run_q       <= run_d;
      aw_full_q   <= aw_full_d;
      aw_addr_q   <= aw_addr_d;
      w_full_q    <= w_full_d;
      w_data_q    <= w_data_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      wr_count_q  <= wr_count_d;
      err_count_q <= err_count_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= w_data_q;
    end
  end

endmodule

// File: tb/tb_axi_write_sink.sv
// Self-checking bench for axi_write_sink: directed scenarios plus a short random
// burst, with a response scoreboard and a memory/counter model.
module tb_axi_write_sink;

  logic          clk;
  logic          rst_n;
  logic          axi_awvalid;
  logic          axi_awready;
  logic [63:0]   axi_awaddr;
  logic          axi_wvalid;
  logic          axi_wready;
  logic [255:0]  axi_wdata;
  logic          axi_bvalid;
  logic          axi_bready;
  logic [1:0]    axi_bresp;
  logic [7:0]    rd_addr;
  logic [255:0]  rd_data;
  logic [31:0]   wr_count;
  logic [15:0]   err_count;

  int            n_checks;
  int            n_errors;
  logic [1:0]    exp_q[$];
  logic [255:0]  mem_m [int];
  logic [31:0]   exp_wr;
  logic [15:0]   exp_err;

  axi_write_sink dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_awaddr  (axi_awaddr),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_wdata   (axi_wdata),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_bresp   (axi_bresp),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_count    (wr_count),
    .err_count   (err_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: every B handshake pops one expected response code
  always @(negedge clk) begin
    if (rst_n && axi_bvalid && axi_bready) begin
      if (exp_q.size() == 0) begin
        check("bresp_unexpected", 256'd1, 256'd0);
      end else begin
        check("bresp", 256'(axi_bresp), 256'(exp_q.pop_front()));
      end
    end
  end

  // model for BASE_ADDR 0, DEPTH 256: in range below 64'h2000
  task automatic expect_write(input logic [63:0] addr, input logic [255:0] data);
    if (addr < 64'h2000) begin
      exp_q.push_back(2'b00);
      mem_m[int'(addr[12:5])] = data;
      exp_wr++;
    end else begin
      exp_q.push_back(2'b10);
      if (exp_err != 16'hFFFF) exp_err++;
    end
  endtask

  // driver tasks: entered and left just after a rising edge
  task automatic drive_beats(input logic do_aw, input logic do_w,
                             input logic [63:0] addr, input logic [255:0] data);
    logic aw_pend, w_pend, aw_acc, w_acc;
    int cyc;
    aw_pend = do_aw;
    w_pend  = do_w;
    if (do_aw) begin axi_awvalid = 1'b1; axi_awaddr = addr; end
    if (do_w)  begin axi_wvalid  = 1'b1; axi_wdata  = data; end
    cyc = 0;
    while ((aw_pend || w_pend) && cyc < 50) begin
      @(negedge clk);
      aw_acc = axi_awvalid && axi_awready;
      w_acc  = axi_wvalid && axi_wready;
      @(posedge clk); #1;
      if (aw_acc) begin axi_awvalid = 1'b0; aw_pend = 1'b0; end
      if (w_acc)  begin axi_wvalid  = 1'b0; w_pend  = 1'b0; end
      cyc++;
    end
    if (aw_pend || w_pend) begin
      check("beat_timeout", 256'd1, 256'd0);
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
    end
  endtask

  task automatic wait_bvalid();
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!axi_bvalid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!axi_bvalid) check("bvalid_timeout", 256'd1, 256'd0);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [255:0] data);
    expect_write(addr, data);
    drive_beats(1'b1, 1'b1, addr, data);
    wait_bvalid();
    @(posedge clk); #1;
  endtask

  task automatic read_check(input string tag, input logic [7:0] idx, input logic [255:0] exp);
    rd_addr = idx;
    @(posedge clk);
    @(negedge clk);
    check(tag, rd_data, exp);
    @(posedge clk); #1;
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  initial begin
    logic [255:0] a5, d, da, db, dc, x0, x255;
    logic [31:0]  wsnap;
    logic [63:0]  addr;
    int           idx;

    n_checks = 0; n_errors = 0; exp_wr = '0; exp_err = '0;
    rst_n = 1'b0; axi_awvalid = 1'b0; axi_awaddr = '0; axi_wvalid = 1'b0;
    axi_wdata = '0; axi_bready = 1'b0; rd_addr = '0;
    for (int i = 0; i < 32; i++) a5[i*8 +: 8] = 8'hA5;

    // reset values and run-flag start-up
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 256'(axi_awready), 256'd0);
    check("rst_wready", 256'(axi_wready), 256'd0);
    check("rst_bvalid", 256'(axi_bvalid), 256'd0);
    check("rst_bresp", 256'(axi_bresp), 256'd0);
    check("rst_rd_data", rd_data, 256'd0);
    check("rst_wr_count", 256'(wr_count), 256'd0);
    check("rst_err_count", 256'(err_count), 256'd0);
    rst_n = 1'b1;
    check("run_awready_lo", 256'(axi_awready), 256'd0);
    check("run_wready_lo", 256'(axi_wready), 256'd0);
    @(posedge clk); #1;
    check("run_awready_hi", 256'(axi_awready), 256'd1);
    check("run_wready_hi", 256'(axi_wready), 256'd1);
    axi_bready = 1'b1;

    // same-cycle AW and W, response latency
    expect_write(64'h40, a5);
    drive_beats(1'b1, 1'b1, 64'h40, a5);
    check("lat_bvalid_c1", 256'(axi_bvalid), 256'd0);
    @(posedge clk); #1;
    check("lat_bvalid_c2", 256'(axi_bvalid), 256'd1);
    check("lat_bresp", 256'(axi_bresp), 256'd0);
    @(posedge clk); #1;
    check("lat_bvalid_done", 256'(axi_bvalid), 256'd0);
    read_check("rd_word2", 8'd2, a5);
    check("wr_count_1", 256'(wr_count), 256'd1);

    // W first, AW five cycles later; low address bits ignored
    d = rand_word();
    expect_write(64'h25, d);
    drive_beats(1'b0, 1'b1, 64'h0, d);
    check("wfirst_wready", 256'(axi_wready), 256'd0);
    check("wfirst_awready", 256'(axi_awready), 256'd1);
    repeat (5) begin @(posedge clk); #1; end
    check("wfirst_wready_hold", 256'(axi_wready), 256'd0);
    check("wfirst_no_commit", 256'(axi_bvalid), 256'd0);
    drive_beats(1'b1, 1'b0, 64'h25, '0);
    check("wfirst_bvalid_lo", 256'(axi_bvalid), 256'd0);
    @(posedge clk); #1;
    check("wfirst_bvalid_hi", 256'(axi_bvalid), 256'd1);
    @(posedge clk); #1;
    read_check("rd_word1", 8'd1, d);

    // out-of-range writes must not alias words 0 or 255
    x0 = rand_word(); x255 = rand_word();
    do_write(64'h0, x0);
    do_write(64'h1FE0, x255);
    do_write(64'h2000, rand_word());
    do_write(64'hFFFF_FFFF_FFFF_FFE0, rand_word());
    read_check("oor_word0", 8'd0, x0);
    read_check("oor_word255", 8'd255, x255);
    check("oor_err_count", 256'(err_count), 256'd2);
    check("oor_wr_count", 256'(wr_count), 256'(exp_wr));

    // random in-range burst
    for (int i = 0; i < 6; i++) begin
      idx  = $urandom_range(20, 40);
      addr = 64'(idx) * 64'd32 + 64'($urandom_range(0, 31));
      d    = rand_word();
      do_write(addr, d);
      read_check("rand_rd", 8'(idx), mem_m[idx]);
    end
    check("rand_wr_count", 256'(wr_count), 256'(exp_wr));

    // bready stalled while a second pair is held
    axi_bready = 1'b0;
    da = rand_word(); db = rand_word();
    expect_write(64'h140, da);
    drive_beats(1'b1, 1'b1, 64'h140, da);
    wait_bvalid();
    @(posedge clk); #1;
    wsnap = exp_wr;
    expect_write(64'h160, db);
    drive_beats(1'b1, 1'b1, 64'h160, db);
    check("stall_awready", 256'(axi_awready), 256'd0);
    check("stall_wready", 256'(axi_wready), 256'd0);
    repeat (10) begin
      @(negedge clk);
      check("stall_bvalid", 256'(axi_bvalid), 256'd1);
      check("stall_bresp", 256'(axi_bresp), 256'd0);
      check("stall_wr_count", 256'(wr_count), 256'(wsnap));
    end
    @(posedge clk); #1;
    axi_bready = 1'b1;
    @(posedge clk); #1;
    check("stall_bvalid_clr", 256'(axi_bvalid), 256'd0);
    check("stall_no_commit_yet", 256'(wr_count), 256'(wsnap));
    @(posedge clk); #1;
    check("stall_second_bvalid", 256'(axi_bvalid), 256'd1);
    check("stall_second_count", 256'(wr_count), 256'(wsnap + 32'd1));
    @(posedge clk); #1;
    read_check("stall_rd_b", 8'd11, db);
    read_check("stall_rd_a", 8'd10, da);

    // asynchronous reset with a held AW beat and a pending response
    axi_bready = 1'b0;
    dc = rand_word();
    expect_write(64'h180, dc);
    drive_beats(1'b1, 1'b1, 64'h180, dc);
    wait_bvalid();
    @(posedge clk); #1;
    drive_beats(1'b1, 1'b0, 64'h1A0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_awready", 256'(axi_awready), 256'd0);
    check("arst_wready", 256'(axi_wready), 256'd0);
    check("arst_bvalid", 256'(axi_bvalid), 256'd0);
    check("arst_bresp", 256'(axi_bresp), 256'd0);
    check("arst_rd_data", rd_data, 256'd0);
    check("arst_wr_count", 256'(wr_count), 256'd0);
    check("arst_err_count", 256'(err_count), 256'd0);
    exp_q.delete();
    exp_wr = '0; exp_err = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_bready = 1'b1;
    check("arst_run_awready", 256'(axi_awready), 256'd1);
    read_check("arst_keep_word12", 8'd12, dc);
    read_check("arst_keep_word2", 8'd2, a5);
    check("arst_no_stray_write", 256'(wr_count), 256'd0);

    // counter wrap and saturation
    force dut.wr_count_q = 32'hFFFF_FFFF;
    force dut.err_count_q = 16'hFFFF;
    #1;
    release dut.wr_count_q;
    release dut.err_count_q;
    check("force_wr_count", 256'(wr_count), 256'hFFFF_FFFF);
    check("force_err_count", 256'(err_count), 256'hFFFF);
    exp_wr = 32'hFFFF_FFFF; exp_err = 16'hFFFF;
    @(posedge clk); #1;
    d = rand_word();
    do_write(64'h60, d);
    do_write(64'h4000, rand_word());
    check("wrap_wr_count", 256'(wr_count), 256'd0);
    check("wrap_model_wr", 256'(wr_count), 256'(exp_wr));
    check("sat_err_count", 256'(err_count), 256'hFFFF);
    read_check("wrap_rd_word3", 8'd3, d);
    check("scoreboard_empty", 256'(exp_q.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
